// File: rtl/bs_pkg.sv
// Shared definitions for the pipelined barrel shifter: default widths,
// direction encoding and the per-stage payload layout.
package bs_pkg;
    localparam int BS_DATA_W  = 8;
    localparam int BS_SHIFT_W = 3;

    localparam logic BS_DIR_LEFT  = 1'b1;
    localparam logic BS_DIR_RIGHT = 1'b0;

    // Payload carried by each pipeline stage at the default widths.
    typedef struct packed {
        logic [BS_DATA_W-1:0]  data;
        logic [BS_SHIFT_W-1:0] shift_rem;
        logic                  lr;
        logic                  rot;
        logic                  valid;
    } bs_stage_t;
endpackage

// File: rtl/bs_shift_stage.sv
// One registered stage of the logarithmic shifter: shifts by 2**STAGE_IDX when
// its shift bit is set. Rotation support is compiled in with BS_ROTATE_EN.
module bs_shift_stage
    import bs_pkg::*;
#(
    parameter int DATA_W    = BS_DATA_W,
    parameter int SHIFT_W   = BS_SHIFT_W,
    parameter int STAGE_IDX = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHIFT_W-1:0] shift_in,
    input  logic               lr_in,
`ifdef BS_ROTATE_EN
    input  logic               rot_in,
    output logic               rot_out,
`endif
    input  logic               valid_in,
    output logic [DATA_W-1:0]  data_out,
    output logic [SHIFT_W-1:0] shift_out,
    output logic               lr_out,
    output logic               valid_out
);
    localparam int AMT = 2 ** STAGE_IDX;

    logic [DATA_W-1:0] shl;
    logic [DATA_W-1:0] shr;
    logic [DATA_W-1:0] shifted;

    assign shl = data_in << AMT;
    assign shr = data_in >> AMT;

    always_comb begin
        shifted = data_in;
        if (shift_in[STAGE_IDX]) begin
`ifdef BS_ROTATE_EN
            if (rot_in)
                shifted = (lr_in == BS_DIR_LEFT) ? (shl | (data_in >> (DATA_W - AMT)))
                                                 : (shr | (data_in << (DATA_W - AMT)));
            else
                shifted = (lr_in == BS_DIR_LEFT) ? shl : shr;
`else
            shifted = (lr_in == BS_DIR_LEFT) ? shl : shr;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            shift_out <= '0;
            lr_out    <= 1'b0;
            valid_out <= 1'b0;
`ifdef BS_ROTATE_EN
            rot_out   <= 1'b0;
`endif
        end else if (en) begin
            data_out  <= shifted;
            shift_out <= shift_in;
            lr_out    <= lr_in;
            valid_out <= valid_in;
`ifdef BS_ROTATE_EN
            rot_out   <= rot_in;
`endif
        end
    end
endmodule

// File: rtl/bs_pipe_shifter.sv
// Pipelined barrel shifter top: SHIFT_W stages, valid/ready flow control and a
// saturating completed-result counter. Define BS_ROTATE_EN to honour in_rot.
module bs_pipe_shifter
    import bs_pkg::*;
#(
    parameter int DATA_W  = BS_DATA_W,
    parameter int SHIFT_W = BS_SHIFT_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_lr,
    input  logic               in_rot,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   result_count
);
    logic                             advance;
    logic [SHIFT_W:0][DATA_W-1:0]     data_p;
    logic [SHIFT_W:0][SHIFT_W-1:0]    shift_p;
    logic [SHIFT_W:0]                 lr_p;
    logic [SHIFT_W:0]                 valid_p;

    // Whole pipeline moves as one: it only stalls when the final result is blocked.
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    assign data_p[0]  = in_data;
    assign shift_p[0] = in_shift;
    assign lr_p[0]    = in_lr;
    assign valid_p[0] = in_valid;

`ifdef BS_ROTATE_EN
    logic [SHIFT_W:0] rot_p;
    logic             unused_tail;
    assign rot_p[0]    = in_rot;
    assign unused_tail = ^{shift_p[SHIFT_W], lr_p[SHIFT_W], rot_p[SHIFT_W]};
`else
    logic unused_tail;
    assign unused_tail = ^{shift_p[SHIFT_W], lr_p[SHIFT_W], in_rot};
`endif

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        bs_shift_stage #(
            .DATA_W    (DATA_W),
            .SHIFT_W   (SHIFT_W),
            .STAGE_IDX (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .data_in   (data_p[k]),
            .shift_in  (shift_p[k]),
            .lr_in     (lr_p[k]),
`ifdef BS_ROTATE_EN
            .rot_in    (rot_p[k]),
            .rot_out   (rot_p[k+1]),
`endif
            .valid_in  (valid_p[k]),
            .data_out  (data_p[k+1]),
            .shift_out (shift_p[k+1]),
            .lr_out    (lr_p[k+1]),
            .valid_out (valid_p[k+1])
        );
    end

    assign out_data  = data_p[SHIFT_W];
    assign out_valid = valid_p[SHIFT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result_count <= '0;
        else if (out_valid && out_ready && (result_count != '1))
            result_count <= result_count + 1'b1;
    end
endmodule

// File: tb/tb_bs_pipe_shifter.sv
// Directed bench for bs_pipe_shifter (CNT_W = 4 so saturation is reachable).
module tb_bs_pipe_shifter;
    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

`ifdef BS_ROTATE_EN
    localparam logic [7:0] ROTL_EXP = 8'hAD;
    localparam logic [7:0] ROTR_EXP = 8'hB6;
`else
    localparam logic [7:0] ROTL_EXP = 8'hA8;
    localparam logic [7:0] ROTR_EXP = 8'h16;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHIFT_W-1:0] in_shift;
    logic               in_lr;
    logic               in_rot;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [CNT_W-1:0]   result_count;

    always #5 clk = ~clk;

    bs_pipe_shifter #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_shift     (in_shift),
        .in_lr        (in_lr),
        .in_rot       (in_rot),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .result_count (result_count)
    );

    // BRAM-style entries with hand-computed logical results.
    logic [7:0] tbl_d [8] = '{8'h01, 8'h80, 8'hFF, 8'hFF, 8'h3C, 8'h3C, 8'hA5, 8'h96};
    logic [2:0] tbl_s [8] = '{3'd1,  3'd7,  3'd4,  3'd4,  3'd2,  3'd2,  3'd5,  3'd6};
    logic       tbl_l [8] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [7:0] tbl_e [8] = '{8'h02, 8'h01, 8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hA0, 8'h02};

    int         vecs = 0;
    int         errs = 0;
    logic [7:0] expq [$];
    logic [7:0] exp_next;
    int         exp_cnt;
    int         out_hs;
    int         tick_no;
    int         first_out_tick;
    int         last_out_tick;
    bit         accepted;
    int         idx;
    logic [7:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are sampled at the falling edge, inputs change 1 after the rising edge.
    task automatic tick();
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (expq.size() == 0)
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            else
                check("out_data", 32'(out_data), 32'(expq.pop_front()));
            out_hs++;
            last_out_tick = tick_no;
            if (first_out_tick < 0) first_out_tick = tick_no;
            if (exp_cnt < CNT_MAX) exp_cnt++;
        end
        if (accepted) expq.push_back(exp_next);
        @(posedge clk);
        #1;
        tick_no++;
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] sh, input logic lr,
                         input logic rot, input logic [7:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_shift = sh;
        in_lr    = lr;
        in_rot   = rot;
        exp_next = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_shift = 3'd0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        expq.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_lr = 1'b0;
        in_rot = 1'b0; out_ready = 1'b1; exp_next = '0; exp_cnt = 0; out_hs = 0;
        tick_no = 0; first_out_tick = -1; last_out_tick = -1; idx = 0; held = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h00);
        check("reset_count", 32'(result_count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Left shift by 3, latency 3, single-cycle valid.
        drive(8'hB5, 3'd3, 1'b1, 1'b0, 8'hA8);
        tick();
        idle();
        tick();
        check("lat_early_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat3_valid", 32'(out_valid), 32'd1);
        check("lat3_data", 32'(out_data), 32'hA8);
        tick();
        check("one_shot_valid", 32'(out_valid), 32'd0);
        check("count_after_1", 32'(result_count), 32'd1);

        // Right shift, then passthrough; direction flag toggled while in flight.
        drive(8'hB5, 3'd3, 1'b0, 1'b0, 8'h16);
        tick();
        drive(8'hB5, 3'd0, 1'b1, 1'b0, 8'hB5);
        tick();
        idle();
        in_lr = 1'b0;
        repeat (4) tick();
        check("dir_pass_drained", 32'(expq.size()), 32'd0);
        check("count_after_3", 32'(result_count), 32'd3);

        // Rotate requests (rotation only when the feature is compiled in).
        drive(8'hB5, 3'd3, 1'b1, 1'b1, ROTL_EXP);
        tick();
        drive(8'hB5, 3'd3, 1'b0, 1'b1, ROTR_EXP);
        tick();
        idle();
        in_rot = 1'b0;
        repeat (4) tick();
        check("rot_drained", 32'(expq.size()), 32'd0);
        check("rot_count", 32'(result_count), 32'(exp_cnt));

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            drive(tbl_d[i], tbl_s[i], tbl_l[i], 1'b0, tbl_e[i]);
            tick();
        end
        idle();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'h00);
        check("midrst_count", 32'(result_count), 32'd0);
        expq.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(8'h3C, 3'd2, 1'b1, 1'b0, 8'hF0);
        tick();
        idle();
        tick();
        tick();
        check("postrst_valid", 32'(out_valid), 32'd1);
        check("postrst_data", 32'(out_data), 32'hF0);
        tick();
        check("postrst_count", 32'(result_count), 32'd1);

        // Back-to-back stream of 8 entries with out_ready held high.
        pulse_reset();
        tick_no = 0; first_out_tick = -1; last_out_tick = -1; out_hs = 0; idx = 0;
        for (int c = 0; c < 30 && (idx < 8 || expq.size() > 0); c++) begin
            if (idx < 8) drive(tbl_d[idx], tbl_s[idx], tbl_l[idx], 1'b0, tbl_e[idx]);
            else idle();
            tick();
            if (accepted) idx++;
        end
        check("stream_first_tick", 32'(first_out_tick), 32'd3);
        check("stream_span", 32'(last_out_tick - first_out_tick), 32'd7);
        check("stream_results", 32'(out_hs), 32'd8);
        check("stream_count", 32'(result_count), 32'd8);
        check("stream_drained", 32'(expq.size()), 32'd0);

        // Same stream with a 4-cycle downstream stall; counter hits saturation.
        out_hs = 0; idx = 0;
        for (int c = 0; c < 40 && (idx < 8 || expq.size() > 0); c++) begin
            out_ready = !(c >= 5 && c < 9);
            #1;
            if (c == 5) held = out_data;
            if (c >= 5 && c < 9) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_data", 32'(out_data), 32'(held));
            end
            if (idx < 8) drive(tbl_d[idx], tbl_s[idx], tbl_l[idx], 1'b0, tbl_e[idx]);
            else idle();
            tick();
            if (accepted) idx++;
        end
        out_ready = 1'b1;
        check("stall_results", 32'(out_hs), 32'd8);
        check("stall_drained", 32'(expq.size()), 32'd0);
        check("sat_count", 32'(result_count), 32'(CNT_MAX));
        check("sat_model", 32'(result_count), 32'(exp_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/bs_pipe_shifter.md
Name: bs_pipe_shifter

Overview:
- Pipelined logarithmic barrel shifter. Sits directly downstream of the BRAM-driven control unit.
- Consumes one 8-bit operand, a 3-bit shift amount and a direction flag per transaction.
- Produces the shifted result after a fixed pipeline latency, with valid/ready flow control toward the display/capture logic.
- Also keeps a count of completed results for on-board debug.

Parameters:
- DATA_W, 8: operand/result width.
- SHIFT_W, 3: shift-amount width. Equals the number of pipeline stages; DATA_W must be at least 2**(SHIFT_W-1).
- CNT_W, 16: width of the result counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a transaction.
- in_ready  out  1  shifter accepts a transaction this cycle.
- in_data  in  DATA_W  operand.
- in_shift  in  SHIFT_W  shift amount, 0..2**SHIFT_W-1.
- in_lr  in  1  direction: 1 = left, 0 = right.
- in_rot  in  1  rotate request; honoured only with BS_ROTATE_EN, otherwise ignored.
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  shifted result.
- result_count  out  CNT_W  number of completed output handshakes, saturating.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert usage): all stage valid bits = 0, all stage data = 0, out_valid = 0, out_data = 0, result_count = 0. in_ready = 1 immediately after reset.
- Pipeline: SHIFT_W stages. Stage k (k = 0..SHIFT_W-1) shifts by 2**k when its copy of shift[k] = 1, else passes through.
- Each stage registers data, remaining shift bits, lr, rot and valid. Final-stage registers drive out_data/out_valid directly.
- Latency = SHIFT_W cycles from accepted input to out_valid (3 at default).
- Stall rule: advance = out_ready | ~out_valid; in_ready = advance (combinational).
  - advance = 1: every stage loads from its predecessor; stage 0 loads inputs with valid = in_valid.
  - advance = 0: every stage holds. No data loss, no duplication.
- An input transfer occurs iff in_valid & in_ready. Bubbles (in_valid = 0) propagate as valid = 0 slots.
- Output handshake occurs iff out_valid & out_ready. On each handshake, result_count increments; it saturates at all-ones and does not wrap.
- Logical shift fills vacated bits with 0.
- shift = 0: passthrough, latency unchanged.
- Simultaneous handshakes: a new input accepted in the same cycle as an output handshake is normal throughput of 1 result/cycle.
- out_ready held low with a full pipeline: in_ready = 0. The pipeline freezes and out_data stays stable until out_ready rises.
- Reset mid-operation: all in-flight transactions are discarded, outputs return to reset values in the same cycle rst asserts, and result_count clears.
- in_lr and in_rot are sampled with the operand and travel with it. Changing them while a transaction is in flight does not affect that transaction.

Optional Feature:
- Macro BS_ROTATE_EN.
- Defined: when a transaction has rot = 1, each stage rotates instead of shifting, so bits leaving one end enter the other in the chosen direction.
- Not defined: in_rot is unused, all shifts are logical, and no rot bit is registered in the stages.

Decomposition:
- Shared package bs_pkg holds:
  - DATA_W/SHIFT_W defaults
  - direction constants BS_DIR_LEFT = 1, BS_DIR_RIGHT = 0
  - a stage-payload struct {data, shift_rem, lr, rot, valid}
- One natural sub-module: bs_shift_stage.
  - Parameter STAGE_IDX; one registered stage with hold enable.
  - Instantiated SHIFT_W times via generate.
  - Top level holds handshake logic and result_count.

Test Plan:
- Reset, then in_data = 0xB5, in_shift = 3, in_lr = 1 → after 3 cycles out_data = 0xA8, out_valid = 1 for one cycle with out_ready = 1; result_count = 1.
- in_data = 0xB5, in_shift = 3, in_lr = 0 → out_data = 0x16. Then in_shift = 0 → out_data = 0xB5 (passthrough).
- Stream the 8 BRAM-style entries back-to-back with out_ready = 1 → 8 consecutive results, 1 per cycle starting cycle 3, and result_count = 8. Then hold out_ready = 0 for 4 cycles mid-stream → in_ready = 0 once full, out_data stable, no result lost or duplicated.
- Assert rst while 3 transactions are in flight → out_valid = 0, out_data = 0, result_count = 0 in the same cycle. The first post-reset input yields a correct result at latency 3.
- With BS_ROTATE_EN: 0xB5, shift 3, lr = 1, rot = 1 → 0xAD; lr = 0, rot = 1 → 0xB6. Without the macro, the same stimulus → 0xA8 and 0x16.
- Force result_count near all-ones (CNT_W = 4 build, 16 handshakes) → holds at 0xF.
